quant_result_packer: RTL

- Downstream neighbour of the quantizer array.
- Captures one full vector of quantized lane results (QUANTIZER_SIZE lanes × COMPUTE_DATA_WIDTH bits) with a valid/ready handshake.
- Packs the vector into BUS_WIDTH-bit words and streams them to the unified buffer write port as consecutive word addresses, with valid/ready backpressure.
- Sits between the quantizer array output and the buffer writer; it is the only stage that holds quantized results.

---
 rtl/tpu_pkg.sv | 27 ++
 rtl/lane_word_mux.sv | 30 +++
 rtl/quant_result_packer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared types and default widths for the quantizer result path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tpu_pkg;

    // Default geometry of the quantizer array and unified buffer write port.
    localparam int DEFAULT_QUANTIZER_SIZE     = 64;
    localparam int DEFAULT_COMPUTE_DATA_WIDTH = 4;
    localparam int DEFAULT_BUS_WIDTH          = 32;
    localparam int DEFAULT_ADDR_WIDTH         = 16;
    localparam int VEC_COUNT_WIDTH            = 16;

    // One quantized lane result.
    typedef logic [DEFAULT_COMPUTE_DATA_WIDTH-1:0] quant_lane_t;

    // Packer control states: waiting for a vector, or streaming its words.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } packer_state_e;

    // Width of a beat index; a single-word vector still gets a 1-bit counter.
    function automatic int beat_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/lane_word_mux.sv
// Selects one bus word worth of lanes by beat index and concatenates them.
// Latency: combinational.
// Backpressure: none; pure function of the held lanes and beat index.
module lane_word_mux #(
    parameter int LANES      = 64,
    parameter int LANE_WIDTH = 4,
    parameter int WORD_WIDTH = 32,
    parameter int BEAT_WIDTH = 3
) (
    input  logic [LANE_WIDTH-1:0] lanes_i [LANES],
    input  logic [BEAT_WIDTH-1:0] beat_i,
    output logic [WORD_WIDTH-1:0] word_o
);

    localparam int LANES_PER_WORD = WORD_WIDTH / LANE_WIDTH;
    localparam int WORDS          = LANES / LANES_PER_WORD;

    // Every candidate word, pre-packed so the beat index is a plain select.
    logic [WORDS-1:0][WORD_WIDTH-1:0] words;

    // Lowest-indexed lane of each word lands in the least significant bits.
    for (genvar w = 0; w < WORDS; w++) begin : g_word
        for (genvar l = 0; l < LANES_PER_WORD; l++) begin : g_lane
            assign words[w][l*LANE_WIDTH +: LANE_WIDTH] = lanes_i[w*LANES_PER_WORD + l];
        end
    end

    assign word_o = words[beat_i];

endmodule

// File: rtl/quant_result_packer.sv
// Holds one quantized vector and streams it as consecutive bus words to the buffer write port.
// Latency: first beat 1 cycle after accept; WORDS_PER_VEC cycles per vector at full rate.
// Backpressure: wr beat held stable while wr_ready low; in_ready only in IDLE or on the final handshake.
module quant_result_packer
    import tpu_pkg::*;
#(
    parameter int QUANTIZER_SIZE     = DEFAULT_QUANTIZER_SIZE,
    parameter int COMPUTE_DATA_WIDTH = DEFAULT_COMPUTE_DATA_WIDTH,
    parameter int BUS_WIDTH          = DEFAULT_BUS_WIDTH,
    parameter int ADDR_WIDTH         = DEFAULT_ADDR_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [COMPUTE_DATA_WIDTH-1:0] in_data [QUANTIZER_SIZE],
    input  logic [ADDR_WIDTH-1:0]         in_base_addr,
    output logic                          wr_valid,
    input  logic                          wr_ready,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    output logic [BUS_WIDTH-1:0]          wr_data,
    output logic                          wr_last,
    output logic                          busy,
    output logic [VEC_COUNT_WIDTH-1:0]    vec_count
);

    localparam int LANES_PER_WORD = BUS_WIDTH / COMPUTE_DATA_WIDTH;
    localparam int WORDS_PER_VEC  = QUANTIZER_SIZE / LANES_PER_WORD;
    localparam int BEAT_WIDTH     = beat_width(WORDS_PER_VEC);
    localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(WORDS_PER_VEC - 1);

    packer_state_e                state_q, state_d;
    logic [BEAT_WIDTH-1:0]        beat_q, beat_d;
    logic [VEC_COUNT_WIDTH-1:0]   vec_count_q, vec_count_d;
    logic [COMPUTE_DATA_WIDTH-1:0] hold_q [QUANTIZER_SIZE];
    logic [ADDR_WIDTH-1:0]        base_q;

    logic                         sending;
    logic                         last_beat;
    logic                         beat_fire;
    logic                         capture;
    logic [BUS_WIDTH-1:0]         mux_word;

    // Handshake terms shared by the FSM and the port logic.
    assign sending   = (state_q == SEND);
    assign last_beat = (beat_q == LAST_BEAT);
    assign beat_fire = sending && wr_ready;

    // A new vector may enter while idle, or on the handshake that retires the last word.
    assign in_ready = !sending || (beat_fire && last_beat);
    assign capture  = in_valid && in_ready;

    lane_word_mux #(
        .LANES      (QUANTIZER_SIZE),
        .LANE_WIDTH (COMPUTE_DATA_WIDTH),
        .WORD_WIDTH (BUS_WIDTH),
        .BEAT_WIDTH (BEAT_WIDTH)
    ) u_lane_word_mux (
        .lanes_i (hold_q),
        .beat_i  (beat_q),
        .word_o  (mux_word)
    );

    // Outputs are gated by state so reset forces them to zero without clearing the holding register.
    assign wr_valid  = sending;
    assign wr_last   = sending && last_beat;
    assign wr_addr   = sending ? (base_q + ADDR_WIDTH'(beat_q)) : '0;
    assign wr_data   = sending ? mux_word : '0;
    assign busy      = sending;
    assign vec_count = vec_count_q;

    // Next-state: accept, advance beat on handshake, retire or chain vectors on the last beat.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        vec_count_d = vec_count_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SEND;
                    beat_d  = '0;
                end
            end
            SEND: begin
                if (beat_fire) begin
                    if (last_beat) begin
                        vec_count_d = vec_count_q + VEC_COUNT_WIDTH'(1);
                        beat_d      = '0;
                        // A vector offered alongside the last beat continues the stream with no bubble.
                        if (!in_valid) begin
                            state_d = IDLE;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Control state: asynchronous reset abandons any vector in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            vec_count_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            vec_count_q <= vec_count_d;
        end
    end

    // Holding register: contents only matter while sending, so no reset is needed.
    always_ff @(posedge clk) begin
        if (capture) begin
            hold_q <= in_data;
            base_q <= in_base_addr;
        end
    end

endmodule
